wf_playback_ctrl: RTL and testbench
===================================

// Module: wf_playback_ctrl
// PURPOSE
//  Sequences the waveform DPBRAM between the PS-facing AXI4-Lite register block and the DAC/reference datapath.
//  IDLE: PS register writes load the RAM through port A.
//  RUN: a sample-rate tick walks port B through 0..max_cnt-1 and wraps. Each registered sample goes downstream,
//  and the live index returns to PS via wf_read_cnt.
// PARAMETERS
//  ADDR_W    10   DPBRAM address width; DEPTH = 2**ADDR_W = 1024
//  DATA_W    16   waveform sample width
//  TICK_DIV  100  i_clk cycles per sample tick (>=4); 100 -> 1 MS/s at 100 MHz
// PORTS
//  i_clk            in   1       single clock for all logic
//  i_rst            in   1       synchronous, active-high reset
//  i_wf_mode_start  in   1       level from PS; 1 = play, 0 = stop
//  i_wf_write_en    in   1       level from PS; 1 = write addr/data to RAM every cycle while IDLE
//  i_wf_write_addr  in   ADDR_W  port-A write address
//  i_wf_write_data  in   DATA_W  port-A write data
//  i_wf_max_cnt     in   32      number of samples per period
//  o_wf_read_cnt    out  32      index of the sample currently on o_wf_data
//  o_wf_data        out  DATA_W  current waveform sample
//  o_wf_valid       out  1       1-cycle pulse when o_wf_data updates
//  o_wf_cycle_done  out  1       1-cycle pulse with the valid of index max_cnt-1
//  o_wf_busy        out  1       1 in PRIME/RUN
//  o_wf_cnt_err     out  1       sticky: start requested with max_cnt==0; cleared by i_rst or a valid start
// BEHAVIOUR
//  Reset: all outputs 0, FSM=IDLE, rd_addr=0, tick counter=0.
//   RAM contents are not cleared by reset.
//  Start handling:
//   - Start is the rising edge of i_wf_mode_start, taken from a registered copy.
//   - Its falling edge, or start==0 in any state, forces IDLE on the next cycle.
//   - On that stop: o_wf_data=0, o_wf_valid=0, o_wf_busy=0, o_wf_read_cnt=0.
//  Max count:
//   - eff_max = min(i_wf_max_cnt, DEPTH), latched on the start edge.
//   - i_wf_max_cnt changes during RUN are ignored until the next start.
//  FSM:
//   - IDLE -> PRIME on the start edge when eff_max!=0.
//     If eff_max==0: stay in IDLE and set o_wf_cnt_err.
//   - PRIME (1 cycle): issue port-B read of addr 0, clear the tick counter.
//     The first sample is output without waiting for a tick. -> RUN.
//   - RUN: the tick counter counts 0..TICK_DIV-1. At terminal count:
//     rd_addr = (rd_addr==eff_max-1) ? 0 : rd_addr+1, and a read is issued.
//  Read latency:
//   - Port B has a registered output, so data is ready 2 cycles after the read issue.
//   - On that cycle: o_wf_data updates, o_wf_valid pulses, and o_wf_read_cnt takes the issued address.
//   - A 2-stage address/valid pipeline tracks reads in flight.
//   - A stop while a read is in flight squashes that read; no valid is emitted.
//  Port-A writes:
//   - Accepted only in IDLE while i_wf_write_en==1.
//   - In PRIME/RUN they are dropped silently, so port A is gated off.
//   - A write and a start edge in the same cycle: the write completes, then PRIME.
//  Wrap: o_wf_cycle_done pulses together with the valid of index eff_max-1. The next valid carries index 0.
//  Widths:
//   - The tick counter is $clog2(TICK_DIV) bits.
//   - rd_addr is ADDR_W bits, compared against eff_max-1 at ADDR_W+1 bits so that eff_max=DEPTH wraps correctly.
//  i_rst mid-RUN: IDLE next cycle; the pipeline is flushed.
// STRUCTURE
//  Package wf_pkg:
//   - typedef wf_state_t {IDLE, PRIME, RUN}
//   - localparam WF_ADDR_W=10, WF_DATA_W=16
//  Sub-module wf_dpbram:
//   - simple dual-port, ADDR_W x DATA_W; port A write, port B read with a registered output (latency 2 incl. addr reg)
//   - FSM, tick counter and pipeline live in wf_playback_ctrl
// TESTING
//  1. In IDLE write addr 0..3 = 16'h0001..0004, max_cnt=4, TICK_DIV=4, raise start
//     -> valids carry data 1,2,3,4,1,... with read_cnt 0,1,2,3,0; cycle_done pulses with the data-4 valid.
//  2. max_cnt=0, raise start -> stays IDLE, busy=0, cnt_err=1.
//     Then max_cnt=2 with a new start edge -> cnt_err=0, plays 2 samples.
//  3. max_cnt=2000 -> clamped to 1024; the valid after index 1023 carries index 0.
//  4. During RUN, pulse write_en with addr 1 = 16'hBEEF
//     -> RAM unchanged; after stop and replay, addr 1 still holds the old value.
//  5. Drop start 1 cycle after a read issue -> no valid emitted; data=0, read_cnt=0, busy=0 next cycle.
//  6. Assert i_rst mid-RUN for 1 cycle -> all outputs 0, IDLE; RAM contents preserved on the next start.

Source files
------------

// File: rtl/wf_pkg.sv
// Shared types and default widths for the waveform playback block.
// Provides the controller state encoding and RAM geometry defaults.
package wf_pkg;

    localparam int WF_ADDR_W = 10;
    localparam int WF_DATA_W = 16;

    typedef enum logic [1:0] {
        IDLE,
        PRIME,
        RUN
    } wf_state_t;

endpackage

// File: rtl/wf_dpbram.sv
// Simple dual-port waveform RAM: port A writes, port B reads with an
// address register and a resettable output register (read latency 2).
// Ports:
//   clk               single clock
//   a_we/a_addr/a_data port-A write
//   b_en              load the port-B address register
//   b_addr            port-B read address
//   b_oce             load the output register from the addressed word
//   b_rst             synchronous clear of the output register
//   b_data            registered read data
module wf_dpbram #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_data,
    input  logic              b_en,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic              b_oce,
    input  logic              b_rst,
    output logic [DATA_W-1:0] b_data
);

    logic [DATA_W-1:0] mem [2**ADDR_W];
    logic [ADDR_W-1:0] addr_q;

    always_ff @(posedge clk) begin
        if (a_we) begin
            mem[a_addr] <= a_data;
        end
    end

    always_ff @(posedge clk) begin
        if (b_en) begin
            addr_q <= b_addr;
        end
    end

    always_ff @(posedge clk) begin
        if (b_rst) begin
            b_data <= '0;
        end else if (b_oce) begin
            b_data <= mem[addr_q];
        end
    end

endmodule

// File: rtl/wf_playback_ctrl.sv
// Waveform playback sequencer: PS loads the RAM while idle, then a sample
// tick walks the RAM cyclically and streams registered samples downstream.
// Ports:
//   i_clk, i_rst                 clock, synchronous active-high reset
//   i_wf_mode_start              play level (1 play, 0 stop)
//   i_wf_write_en/addr/data      RAM load port, honoured only while idle
//   i_wf_max_cnt                 samples per period (clamped to DEPTH)
//   o_wf_read_cnt, o_wf_data     index and value of the current sample
//   o_wf_valid, o_wf_cycle_done  sample strobe, last-sample-of-period strobe
//   o_wf_busy, o_wf_cnt_err      playing flag, sticky zero-length error
module wf_playback_ctrl
    import wf_pkg::*;
#(
    parameter int ADDR_W   = WF_ADDR_W,
    parameter int DATA_W   = WF_DATA_W,
    parameter int TICK_DIV = 100
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_wf_mode_start,
    input  logic              i_wf_write_en,
    input  logic [ADDR_W-1:0] i_wf_write_addr,
    input  logic [DATA_W-1:0] i_wf_write_data,
    input  logic [31:0]       i_wf_max_cnt,
    output logic [31:0]       o_wf_read_cnt,
    output logic [DATA_W-1:0] o_wf_data,
    output logic              o_wf_valid,
    output logic              o_wf_cycle_done,
    output logic              o_wf_busy,
    output logic              o_wf_cnt_err
);

    localparam int TW = $clog2(TICK_DIV);
    localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

    wf_state_t state, state_nx;

    logic              start_q;
    logic              start_edge;
    logic              stop;
    logic [ADDR_W:0]   max_clamp;
    logic [ADDR_W:0]   eff_max;
    logic [ADDR_W-1:0] rd_addr;
    logic [ADDR_W-1:0] addr_nx;
    logic [TW-1:0]     tick;
    logic              tick_tc;
    logic              at_last;
    logic              issue;
    logic              ram_we;
    logic              v1;
    logic [ADDR_W-1:0] a1;

    assign start_edge = i_wf_mode_start & ~start_q;
    assign stop       = ~i_wf_mode_start;
    assign max_clamp  = (i_wf_max_cnt > 32'(DEPTH)) ? DEPTH
                                                    : i_wf_max_cnt[ADDR_W:0];
    assign tick_tc    = (tick == TW'(TICK_DIV - 1));
    // Compared one bit wider so eff_max == DEPTH wraps at DEPTH-1.
    assign at_last    = ({1'b0, rd_addr} == eff_max - 1'b1);
    assign o_wf_busy  = (state != IDLE);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        issue    = 1'b0;
        addr_nx  = rd_addr;
        ram_we   = 1'b0;
        unique case (state)
            IDLE: begin
                ram_we = i_wf_write_en;
                if (start_edge && (max_clamp != '0)) begin
                    state_nx = PRIME;
                end
            end
            PRIME: begin
                issue    = 1'b1;
                addr_nx  = '0;
                state_nx = RUN;
            end
            RUN: begin
                if (tick_tc) begin
                    issue   = 1'b1;
                    addr_nx = at_last ? '0 : rd_addr + 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
        if (stop) begin
            state_nx = IDLE;
            issue    = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            start_q         <= 1'b0;
            eff_max         <= '0;
            rd_addr         <= '0;
            tick            <= '0;
            v1              <= 1'b0;
            a1              <= '0;
            o_wf_valid      <= 1'b0;
            o_wf_read_cnt   <= '0;
            o_wf_cycle_done <= 1'b0;
            o_wf_cnt_err    <= 1'b0;
        end else begin
            start_q <= i_wf_mode_start;
            if ((state == IDLE) && start_edge) begin
                eff_max      <= max_clamp;
                o_wf_cnt_err <= (max_clamp == '0);
            end
            if (issue) begin
                rd_addr <= addr_nx;
            end
            if ((state == RUN) && !tick_tc) begin
                tick <= tick + 1'b1;
            end else begin
                tick <= '0;
            end
            // Stage 1 mirrors the RAM address register; stage 2 is
            // the output register set, aligned with RAM read data.
            v1 <= issue;
            a1 <= addr_nx;
            if (stop) begin
                o_wf_valid      <= 1'b0;
                o_wf_read_cnt   <= '0;
                o_wf_cycle_done <= 1'b0;
            end else begin
                o_wf_valid      <= v1;
                o_wf_cycle_done <= v1 && ({1'b0, a1} == eff_max - 1'b1);
                if (v1) begin
                    o_wf_read_cnt <= 32'(a1);
                end
            end
        end
    end

    wf_dpbram #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_ram (
        .clk    (i_clk),
        .a_we   (ram_we),
        .a_addr (i_wf_write_addr),
        .a_data (i_wf_write_data),
        .b_en   (issue),
        .b_addr (addr_nx),
        .b_oce  (v1 & ~stop),
        .b_rst  (i_rst | stop),
        .b_data (o_wf_data)
    );

endmodule

// File: tb/tb_wf_playback_ctrl.sv
// Self-checking bench for wf_playback_ctrl with a sample-schedule model.
// Expected samples come from a RAM shadow and a modular period index.
module tb_wf_playback_ctrl;

    localparam int TD    = 4;
    localparam int DEPTH = 1024;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        we;
    logic [9:0]  waddr;
    logic [15:0] wdata;
    logic [31:0] max_cnt;
    logic [31:0] read_cnt;
    logic [15:0] data;
    logic        valid;
    logic        done;
    logic        busy;
    logic        cnt_err;

    logic [15:0] model [DEPTH];

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    wf_playback_ctrl #(
        .ADDR_W   (10),
        .DATA_W   (16),
        .TICK_DIV (TD)
    ) dut (
        .i_clk           (clk),
        .i_rst           (rst),
        .i_wf_mode_start (start),
        .i_wf_write_en   (we),
        .i_wf_write_addr (waddr),
        .i_wf_write_data (wdata),
        .i_wf_max_cnt    (max_cnt),
        .o_wf_read_cnt   (read_cnt),
        .o_wf_data       (data),
        .o_wf_valid      (valid),
        .o_wf_cycle_done (done),
        .o_wf_busy       (busy),
        .o_wf_cnt_err    (cnt_err)
    );

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     tag, got, exp, $time);
        end
    endtask

    task automatic zeros(string tag);
        check({tag, "_valid"}, 32'(valid), 0);
        check({tag, "_data"}, 32'(data), 0);
        check({tag, "_cnt"}, read_cnt, 0);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_done"}, 32'(done), 0);
    endtask

    task automatic wr(int a, logic [15:0] d);
        @(negedge clk);
        we    = 1'b1;
        waddr = 10'(a);
        wdata = d;
        model[a] = d;
    endtask

    task automatic wr_end();
        @(negedge clk);
        we = 1'b0;
    endtask

    // Raise start and follow nval sample slots. Optional: a RUN-time
    // write at slot wr_at, a stop/reset at kill_at, and a RAM write in
    // the same cycle as the start edge (cw).
    task automatic play(int mx, int nval, int wr_at,
                        int kill_at, bit kill_rst, bit cw);
        int eff;
        int idx;
        int last;
        bit ev;
        logic [15:0] d;
        eff  = (mx > DEPTH) ? DEPTH : mx;
        idx  = 0;
        last = 3 + (nval - 1) * TD;
        @(negedge clk);
        max_cnt = 32'(mx);
        start   = 1'b1;
        if (cw) begin
            d = 16'($urandom);
            we = 1'b1;
            waddr = '0;
            wdata = d;
            model[0] = d;
        end
        for (int j = 1; j <= last; j++) begin
            @(negedge clk);
            if (kill_at > 0 && j == kill_at + 1) begin
                zeros(kill_rst ? "rst" : "stop");
                if (kill_rst) begin
                    check("rst_err", 32'(cnt_err), 0);
                end
                rst   = 1'b0;
                start = 1'b0;
                we    = 1'b0;
                return;
            end
            ev = (j >= 3) && ((j - 3) % TD == 0);
            check("valid", 32'(valid), 32'(ev));
            check("done", 32'(done), 32'(ev && idx == eff - 1));
            check("busy", 32'(busy), 1);
            if (j == 1) begin
                check("cnt_err", 32'(cnt_err), 0);
            end
            if (ev) begin
                check("data", 32'(data), 32'(model[idx]));
                check("read_cnt", read_cnt, 32'(idx));
                idx = (idx + 1) % eff;
            end
            if (j == wr_at) begin
                we    = 1'b1;
                waddr = 10'd1;
                wdata = 16'hBEEF;
            end else begin
                we = 1'b0;
            end
            if (j == kill_at) begin
                if (kill_rst) begin
                    rst = 1'b1;
                end else begin
                    start = 1'b0;
                end
            end
            if (j == last) begin
                start = 1'b0;
            end
        end
        @(negedge clk);
        zeros("end");
    endtask

    initial begin
        int m;
        rst     = 1'b1;
        start   = 1'b0;
        we      = 1'b0;
        waddr   = '0;
        wdata   = '0;
        max_cnt = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        zeros("reset");
        check("reset_err", 32'(cnt_err), 0);

        // Basic playback with wrap.
        for (int a = 0; a < 4; a++) wr(a, 16'(a + 1));
        wr_end();
        play(4, 7, 0, 0, 1'b0, 1'b0);

        // Zero-length start is refused and flagged.
        @(negedge clk);
        max_cnt = 0;
        start   = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check("zero_busy", 32'(busy), 0);
            check("zero_valid", 32'(valid), 0);
        end
        check("zero_err", 32'(cnt_err), 1);
        start = 1'b0;
        @(negedge clk);
        play(2, 4, 0, 0, 1'b0, 1'b0);

        // Writes during RUN are dropped.
        play(4, 6, 8, 0, 1'b0, 1'b0);
        play(4, 5, 0, 0, 1'b0, 1'b0);

        // Stop squashes reads in flight (PRIME read and a RUN read).
        play(4, 3, 0, 2, 1'b0, 1'b0);
        play(4, 3, 0, 2 + TD, 1'b0, 1'b0);

        // Reset mid-RUN, then RAM contents survive.
        play(4, 4, 0, 5, 1'b1, 1'b0);
        play(4, 5, 0, 0, 1'b0, 1'b0);

        // Randomized short periods, some with a write on the start edge.
        for (int r = 0; r < 4; r++) begin
            m = int'($urandom_range(1, 8));
            for (int a = 0; a < m; a++) wr(a, 16'($urandom));
            wr_end();
            play(m, int'($urandom_range(m + 1, 2 * m + 2)), 0, 0,
                 1'b0, r[0]);
        end

        // Oversized max_cnt clamps to the full RAM.
        for (int a = 0; a < DEPTH; a++) wr(a, 16'($urandom));
        wr_end();
        play(2000, DEPTH + 2, 0, 0, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
